// File: rtl/door_seq_pkg.sv
// door_seq_pkg: shared types and default timing for the door sequencer.
//   door_state_e : supervisory state, encoding is visible on db_state
//   door_dir_e   : direction to resume after a reversal dead-time
package door_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_CLOSED  = 3'b001,
    ST_OPEN    = 3'b010,
    ST_OPENING = 3'b011,
    ST_CLOSING = 3'b100,
    ST_DEAD    = 3'b101,
    ST_FAULT   = 3'b110
  } door_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } door_dir_e;

  localparam int HOLD_CYCLES_DEF     = 20;
  localparam int TIMEOUT_CYCLES_DEF  = 40;
  localparam int DEADTIME_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/door_rr_arb.sv
// door_rr_arb: two-requester round-robin arbiter.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   a_up/a_down, b_up/b_down  raw level requests; up+down together is no request
//   accept                the winning request was acted on this cycle
//   gnt_a, gnt_b          one-hot winner (combinational)
//   win_up, win_down      direction requested by the winner
module door_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic a_up,
  input  logic a_down,
  input  logic b_up,
  input  logic b_down,
  input  logic accept,
  output logic gnt_a,
  output logic gnt_b,
  output logic win_up,
  output logic win_down
);

  logic valid_a, valid_b, ptr_b;

  assign valid_a = a_up ^ a_down;
  assign valid_b = b_up ^ b_down;

  always_comb begin
    gnt_a = valid_a;
    gnt_b = valid_b;
    if (valid_a && valid_b) begin
      gnt_a = ~ptr_b;
      gnt_b = ptr_b;
    end
  end

  assign win_up   = (gnt_a & a_up)   | (gnt_b & b_up);
  assign win_down = (gnt_a & a_down) | (gnt_b & b_down);

  // The pointer only moves when it actually decided a contended, accepted request.
  always_ff @(posedge clk) begin
    if (rst) ptr_b <= 1'b0;
    else if (accept && valid_a && valid_b) ptr_b <= ~ptr_b;
  end

endmodule

// File: rtl/door_sequencer.sv
// door_sequencer: supervisory controller in front of the door FSM.
// Arbitrates two requesters, pulses key_up/key_down (both high = stop),
// auto-closes after a hold time, reverses on obstruction with a dead-time,
// and latches a fault on motor-run timeout or inconsistent sensors.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_a_*, req_b_*              level requests from panel (A) and remote (B)
//   sense_up, sense_down, obstruct door sensors
//   clear_fault                   leave FAULT when sensors are consistent
//   key_up, key_down              registered one-cycle pulses to the door FSM
//   grant_a, grant_b              registered one-cycle acknowledges
//   busy, fault, db_state         status decoded from the state register
// Optional: define DOOR_SEQ_LOCK_EN to add input lock / output lock_denied.
module door_sequencer
  import door_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
  parameter int DEADTIME_CYCLES = DEADTIME_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a_up,
  input  logic       req_a_down,
  input  logic       req_b_up,
  input  logic       req_b_down,
  input  logic       sense_up,
  input  logic       sense_down,
  input  logic       obstruct,
  input  logic       clear_fault,
`ifdef DOOR_SEQ_LOCK_EN
  input  logic       lock,
  output logic       lock_denied,
`endif
  output logic       key_up,
  output logic       key_down,
  output logic       grant_a,
  output logic       grant_b,
  output logic       busy,
  output logic       fault,
  output logic [2:0] db_state
);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  door_state_e      state_q, state_d;
  door_dir_e        dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic key_up_d, key_down_d, accept;
  logic gnt_a, gnt_b, win_up, win_down, up_locked;

`ifdef DOOR_SEQ_LOCK_EN
  logic lock_denied_d;
  assign up_locked = lock;
`else
  assign up_locked = 1'b0;
`endif

  door_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .a_up     (req_a_up),
    .a_down   (req_a_down),
    .b_up     (req_b_up),
    .b_down   (req_b_down),
    .accept   (accept),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .win_up   (win_up),
    .win_down (win_down)
  );

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    key_up_d   = 1'b0;
    key_down_d = 1'b0;
    accept     = 1'b0;
`ifdef DOOR_SEQ_LOCK_EN
    lock_denied_d = 1'b0;
`endif
    if (sense_up && sense_down && state_q != ST_FAULT) begin
      key_up_d   = 1'b1;
      key_down_d = 1'b1;
      state_d    = ST_FAULT;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sense_down) begin
            state_d = ST_CLOSED;
            cnt_d   = '0;
          end else if (sense_up) begin
            state_d = ST_OPEN;
            cnt_d   = HOLD_LD;
          end else if (win_up) begin
            key_up_d = 1'b1;
            accept   = 1'b1;
            state_d  = ST_OPENING;
            cnt_d    = '0;
          end else if (win_down) begin
            key_down_d = 1'b1;
            accept     = 1'b1;
            state_d    = ST_CLOSING;
            cnt_d      = '0;
          end
        end
        ST_CLOSED: begin
          if (win_up) begin
            if (up_locked) begin
`ifdef DOOR_SEQ_LOCK_EN
              lock_denied_d = 1'b1;
`endif
            end else begin
              key_up_d = 1'b1;
              accept   = 1'b1;
              state_d  = ST_OPENING;
              cnt_d    = '0;
            end
          end
        end
        ST_OPENING: begin
          cnt_d = cnt_q + ONE;
          if (sense_up) begin
            state_d = ST_OPEN;
            cnt_d   = HOLD_LD;
          end else if (cnt_q == TMO_LAST) begin
            key_up_d   = 1'b1;
            key_down_d = 1'b1;
            state_d    = ST_FAULT;
            cnt_d      = '0;
          end else if (win_down) begin
            key_up_d   = 1'b1;
            key_down_d = 1'b1;
            accept     = 1'b1;
            state_d    = ST_DEAD;
            dir_d      = DIR_DOWN;
            cnt_d      = '0;
          end
        end
        ST_OPEN: begin
          if (win_down) begin
            key_down_d = 1'b1;
            accept     = 1'b1;
            state_d    = ST_CLOSING;
            cnt_d      = '0;
          end else if (win_up) begin
            accept = 1'b1;
            cnt_d  = HOLD_LD;
          end else if (obstruct) begin
            cnt_d = HOLD_LD;
          end else if (cnt_q == ONE) begin
            // hold expires: auto-close, nobody is granted
            key_down_d = 1'b1;
            state_d    = ST_CLOSING;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        ST_CLOSING: begin
          cnt_d = cnt_q + ONE;
          if (obstruct) begin
            key_up_d   = 1'b1;
            key_down_d = 1'b1;
            state_d    = ST_DEAD;
            dir_d      = DIR_UP;
            cnt_d      = '0;
          end else if (sense_down) begin
            state_d = ST_CLOSED;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            key_up_d   = 1'b1;
            key_down_d = 1'b1;
            state_d    = ST_FAULT;
            cnt_d      = '0;
          end else if (win_up) begin
            key_up_d   = 1'b1;
            key_down_d = 1'b1;
            accept     = 1'b1;
            state_d    = ST_DEAD;
            dir_d      = DIR_UP;
            cnt_d      = '0;
          end
        end
        ST_DEAD: begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == DEAD_LAST) begin
            cnt_d = '0;
            if (dir_q == DIR_UP) begin
              key_up_d = 1'b1;
              state_d  = ST_OPENING;
            end else begin
              key_down_d = 1'b1;
              state_d    = ST_CLOSING;
            end
          end
        end
        ST_FAULT: begin
          if (clear_fault && !(sense_up && sense_down)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      cnt_q    <= '0;
      key_up   <= 1'b0;
      key_down <= 1'b0;
      grant_a  <= 1'b0;
      grant_b  <= 1'b0;
`ifdef DOOR_SEQ_LOCK_EN
      lock_denied <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      key_up   <= key_up_d;
      key_down <= key_down_d;
      grant_a  <= accept & gnt_a;
      grant_b  <= accept & gnt_b;
`ifdef DOOR_SEQ_LOCK_EN
      lock_denied <= lock_denied_d;
`endif
    end
  end

  assign busy     = (state_q == ST_OPENING) || (state_q == ST_CLOSING) || (state_q == ST_DEAD);
  assign fault    = (state_q == ST_FAULT);
  assign db_state = state_q;

endmodule

// File: tb/tb_door_sequencer.sv
module tb_door_sequencer;

  localparam int HOLD = 20;
  localparam int TMO  = 40;
  localparam int DT   = 4;

  localparam int M_IDLE = 0, M_CLOSED = 1, M_OPEN = 2, M_OPENING = 3,
                 M_CLOSING = 4, M_DEAD = 5, M_FAULT = 6;

  logic clk = 1'b0;
  logic rst, req_a_up, req_a_down, req_b_up, req_b_down;
  logic sense_up, sense_down, obstruct, clear_fault;
  logic key_up, key_down, grant_a, grant_b, busy, fault;
  logic [2:0] db_state;
`ifdef DOOR_SEQ_LOCK_EN
  logic lock, lock_denied;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  door_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_a_up    (req_a_up),
    .req_a_down  (req_a_down),
    .req_b_up    (req_b_up),
    .req_b_down  (req_b_down),
    .sense_up    (sense_up),
    .sense_down  (sense_down),
    .obstruct    (obstruct),
    .clear_fault (clear_fault),
`ifdef DOOR_SEQ_LOCK_EN
    .lock        (lock),
    .lock_denied (lock_denied),
`endif
    .key_up      (key_up),
    .key_down    (key_down),
    .grant_a     (grant_a),
    .grant_b     (grant_b),
    .busy        (busy),
    .fault       (fault),
    .db_state    (db_state)
  );

  // Behavioural reference: mode plus independent timers per activity.
  int m_mode, m_hold, m_run, m_dead;
  bit m_rev_up, m_prefer_b;
  bit e_ku, e_kd, e_ga, e_gb, e_ld;

  always @(posedge clk) begin
    bit va, vb, pa, pb, w_up, w_dn, took, ku, kd, ld, lk;
    va = req_a_up ^ req_a_down;
    vb = req_b_up ^ req_b_down;
    pa = va && (!vb || !m_prefer_b);
    pb = vb && (!va || m_prefer_b);
    w_up = (pa && req_a_up) || (pb && req_b_up);
    w_dn = (pa && req_a_down) || (pb && req_b_down);
`ifdef DOOR_SEQ_LOCK_EN
    lk = lock;
`else
    lk = 1'b0;
`endif
    took = 0; ku = 0; kd = 0; ld = 0;
    if (rst) begin
      m_mode = M_IDLE; m_hold = 0; m_run = 0; m_dead = 0;
      m_rev_up = 0; m_prefer_b = 0;
    end else if (sense_up && sense_down && m_mode != M_FAULT) begin
      ku = 1; kd = 1; m_mode = M_FAULT;
    end else begin
      case (m_mode)
        M_IDLE:
          if (sense_down) m_mode = M_CLOSED;
          else if (sense_up) begin m_mode = M_OPEN; m_hold = HOLD; end
          else if (w_up) begin ku = 1; took = 1; m_mode = M_OPENING; m_run = 0; end
          else if (w_dn) begin kd = 1; took = 1; m_mode = M_CLOSING; m_run = 0; end
        M_CLOSED:
          if (w_up) begin
            if (lk) ld = 1;
            else begin ku = 1; took = 1; m_mode = M_OPENING; m_run = 0; end
          end
        M_OPENING: begin
          m_run++;
          if (sense_up) begin m_mode = M_OPEN; m_hold = HOLD; end
          else if (m_run == TMO) begin ku = 1; kd = 1; m_mode = M_FAULT; end
          else if (w_dn) begin
            ku = 1; kd = 1; took = 1; m_mode = M_DEAD; m_rev_up = 0; m_dead = 0;
          end
        end
        M_OPEN:
          if (w_dn) begin kd = 1; took = 1; m_mode = M_CLOSING; m_run = 0; end
          else if (w_up) begin took = 1; m_hold = HOLD; end
          else if (obstruct) m_hold = HOLD;
          else begin
            m_hold--;
            if (m_hold == 0) begin kd = 1; m_mode = M_CLOSING; m_run = 0; end
          end
        M_CLOSING: begin
          m_run++;
          if (obstruct) begin ku = 1; kd = 1; m_mode = M_DEAD; m_rev_up = 1; m_dead = 0; end
          else if (sense_down) m_mode = M_CLOSED;
          else if (m_run == TMO) begin ku = 1; kd = 1; m_mode = M_FAULT; end
          else if (w_up) begin
            ku = 1; kd = 1; took = 1; m_mode = M_DEAD; m_rev_up = 1; m_dead = 0;
          end
        end
        M_DEAD: begin
          m_dead++;
          if (m_dead == DT) begin
            m_run = 0;
            if (m_rev_up) begin ku = 1; m_mode = M_OPENING; end
            else begin kd = 1; m_mode = M_CLOSING; end
          end
        end
        default:
          if (clear_fault && !(sense_up && sense_down)) m_mode = M_IDLE;
      endcase
      if (took && va && vb) m_prefer_b = !m_prefer_b;
    end
    e_ku = ku; e_kd = kd; e_ga = took && pa; e_gb = took && pb; e_ld = ld;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("key_up", {7'd0, key_up}, {7'd0, e_ku});
      check("key_down", {7'd0, key_down}, {7'd0, e_kd});
      check("grant_a", {7'd0, grant_a}, {7'd0, e_ga});
      check("grant_b", {7'd0, grant_b}, {7'd0, e_gb});
      check("db_state", {5'd0, db_state}, 8'(m_mode));
      check("busy", {7'd0, busy}, {7'd0, (m_mode >= M_OPENING && m_mode <= M_DEAD)});
      check("fault", {7'd0, fault}, {7'd0, (m_mode == M_FAULT)});
`ifdef DOOR_SEQ_LOCK_EN
      check("lock_denied", {7'd0, lock_denied}, {7'd0, e_ld});
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [7:0] act, input logic [7:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    rst = 1; req_a_up = 0; req_a_down = 0; req_b_up = 0; req_b_down = 0;
    sense_up = 0; sense_down = 0; obstruct = 0; clear_fault = 0;
`ifdef DOOR_SEQ_LOCK_EN
    lock = 0;
`endif
    cyc(2);
    chk_en = 1;
    pin("reset_state", {5'd0, db_state}, 8'h00);
    pin("reset_keys", {6'd0, key_up, key_down}, 8'h00);
    pin("reset_flags", {4'd0, grant_a, grant_b, busy, fault}, 8'h00);

    // closed -> open via requester A
    rst = 0; sense_down = 1; cyc(1);
    pin("closed", {5'd0, db_state}, 8'h01);
    sense_down = 0; req_a_up = 1; cyc(1); req_a_up = 0;
    pin("open_grant", {6'd0, grant_a, key_up}, 8'h03);
    pin("opening", {5'd0, db_state}, 8'h03);
    sense_up = 1; cyc(1);
    pin("open", {5'd0, db_state}, 8'h02);

    // auto-close after the hold time
    cyc(HOLD - 1);
    pin("hold_no_close", {7'd0, key_down}, 8'h00);
    cyc(1);
    pin("auto_close", {4'd0, key_down, db_state}, 8'h0C);

    // obstruction while closing reverses after the dead-time
    sense_up = 0; obstruct = 1; cyc(1); obstruct = 0;
    pin("stop_pulse", {5'd0, key_up, key_down, 1'b0}, 8'h06);
    pin("dead", {5'd0, db_state}, 8'h05);
    cyc(DT - 1);
    pin("dead_hold", {4'd0, key_up, db_state}, 8'h05);
    cyc(1);
    pin("reverse_up", {4'd0, key_up, db_state}, 8'h0B);

    // obstruction during hold restarts it
    sense_up = 1; cyc(1);
    obstruct = 1; cyc(5); obstruct = 0;
    cyc(HOLD - 1);
    pin("obst_hold", {4'd0, key_down, db_state}, 8'h02);
    cyc(1);
    pin("obst_close", {4'd0, key_down, db_state}, 8'h0C);

    // simultaneous requests alternate
    sense_up = 0; sense_down = 1; cyc(1); sense_down = 0;
    req_a_up = 1; req_b_up = 1; cyc(1); req_a_up = 0; req_b_up = 0;
    pin("rr_first", {6'd0, grant_a, grant_b}, 8'h02);
    req_a_down = 1; cyc(1); req_a_down = 0;
    cyc(DT);
    sense_down = 1; cyc(1); sense_down = 0;
    req_a_up = 1; req_b_up = 1; cyc(1); req_a_up = 0; req_b_up = 0;
    pin("rr_second", {6'd0, grant_a, grant_b}, 8'h01);

    // watchdog
    cyc(TMO - 1);
    pin("wd_running", {4'd0, fault, db_state}, 8'h03);
    cyc(1);
    pin("wd_fault", {3'd0, key_up, key_down, db_state}, 8'h1E);
    req_a_up = 1; cyc(2); req_a_up = 0;
    pin("fault_ignores", {4'd0, grant_a, db_state}, 8'h06);
    clear_fault = 1; cyc(1); clear_fault = 0;
    pin("fault_clear", {5'd0, db_state}, 8'h00);

    // sensor error, then reset mid-motion
    sense_up = 1; cyc(1);
    sense_down = 1; cyc(1);
    pin("sensor_err", {5'd0, db_state}, 8'h06);
    sense_up = 0; sense_down = 0; clear_fault = 1; cyc(1); clear_fault = 0;
    req_b_down = 1; cyc(1); req_b_down = 0;
    pin("closing_b", {4'd0, grant_b, db_state}, 8'h0C);
    cyc(2);
    rst = 1; cyc(1); rst = 0;
    pin("rst_motion", {1'b0, key_up, key_down, grant_a, grant_b, db_state[2:0]}, 8'h00);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      req_a_up    = ($urandom_range(0, 99) < 25);
      req_a_down  = ($urandom_range(0, 99) < 20);
      req_b_up    = ($urandom_range(0, 99) < 25);
      req_b_down  = ($urandom_range(0, 99) < 20);
      sense_up    = ($urandom_range(0, 99) < 8);
      sense_down  = ($urandom_range(0, 99) < 8);
      obstruct    = ($urandom_range(0, 99) < 6);
      clear_fault = ($urandom_range(0, 99) < 20);
`ifdef DOOR_SEQ_LOCK_EN
      lock        = ($urandom_range(0, 99) < 30);
`endif
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
